axi_slave_read: RTL
===================

AXI_SLAVE_READ -- requirements
Module: axi_slave_read

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 2, AXI ID width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width for both ports.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, address width (AW) for both ports.
REQ-004 SHALL have parameter LGFIFO, default 4, log2 of the maximum number of outstanding AXI bursts.
REQ-005 SHALL have one clock and a synchronous, active-high reset: S_AXI_ACLK input 1, the single clock; S_AXI_ARESET input 1, synchronous active-high reset.
REQ-006 SHALL have the AR channel in: S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_ARID in IW; S_AXI_ARADDR in AW; S_AXI_ARLEN in 8; S_AXI_ARSIZE in 3; S_AXI_ARBURST in 2.
REQ-007 SHALL have AR sideband inputs S_AXI_ARLOCK in 1, S_AXI_ARCACHE in 4, S_AXI_ARPROT in 3 and S_AXI_ARQOS in 4; LOCK, CACHE and QOS are unused.
REQ-008 SHALL have the R channel out: S_AXI_RVALID out 1; S_AXI_RREADY in 1; S_AXI_RID out IW; S_AXI_RDATA out DW; S_AXI_RRESP out 2; S_AXI_RLAST out 1.
REQ-009 SHALL have the AXI-lite master side: M_AXI_ARADDR out AW; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_RDATA in DW; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-010 SHALL hold S_AXI_ARREADY = !reset && !burst_fifo_full && (!M_AXI_ARVALID || (beats_left==0 && M_AXI_ARREADY)).
REQ-011 SHALL, on an S AR handshake in cycle N, assert M_AXI_ARVALID in N+1 with ARADDR, load beats_left=ARLEN, and register ARSIZE, ARBURST, ARLEN and ARPROT.
REQ-012 SHALL, on each M AR handshake with beats_left>0, decrement beats_left and advance the address; with beats_left==0, drop M_AXI_ARVALID unless a new burst is accepted in the same cycle.
REQ-013 SHALL advance the address per burst type: FIXED holds; INCR adds 2^ARSIZE modulo 2^AW; WRAP increments within an aligned (ARLEN+1)<<ARSIZE window; reserved 2'b11 behaves as INCR.
REQ-014 SHALL issue exactly ARLEN+1 AXI-lite reads per accepted burst, in order, with no gap between consecutive bursts when M_AXI_ARREADY=1.
REQ-015 SHALL push {ARID, ARLEN} into a FIFO of depth 2^LGFIFO on each S AR handshake; full blocks ARREADY.
REQ-016 SHALL hold M_AXI_RREADY = !S_AXI_RVALID || S_AXI_RREADY.
REQ-017 SHALL, on an M R handshake in cycle K, present in K+1: S_AXI_RVALID=1, RDATA=M_AXI_RDATA, per-beat RRESP=M_AXI_RRESP, RID=FIFO head ID.
REQ-018 SHALL count returned beats of the head burst and assert RLAST when the count equals the head ARLEN, popping the FIFO and clearing the count on that beat.
REQ-019 SHALL hold all S R outputs stable while S_AXI_RVALID && !S_AXI_RREADY, and deassert RVALID after acceptance when no new M beat arrives.
REQ-020 SHALL accept a FIFO push and pop in the same cycle when full, keeping the occupancy unchanged.
REQ-021 SHALL support up to 2^LGFIFO bursts outstanding, each of up to 256 beats.

Reset
REQ-022 SHALL, while S_AXI_ARESET=1, drive S_AXI_ARREADY=0, M_AXI_ARVALID=0 and S_AXI_RVALID=0, set S_AXI_RLAST=0, empty the FIFO and clear beats_left and the beat count.
REQ-023 SHALL abandon any in-flight burst on reset mid-operation, with no residual beats after reset.
REQ-024 SHALL leave data and address registers non-reset.

Structure
REQ-025 SHALL place the burst codes (FIXED=0, INCR=1, WRAP=2) and the RRESP codes (OKAY, EXOKAY, SLVERR, DECERR) in the shared package axi_pkg.
REQ-026 SHALL reuse the existing sfifo for the burst FIFO and the existing axi_addr for next-address calculation; no new sub-module.

Verification
REQ-027 SHALL cover a single beat: ARID=2, ARADDR=0x10, ARLEN=0, INCR, size 2, M R 0xDEADBEEF/OKAY -> one M read at 0x10; S R RID=2, RDATA=0xDEADBEEF, RLAST=1.
REQ-028 SHALL cover INCR: ARADDR=0x08, ARLEN=3, size 2 -> M addresses 0x08, 0x0C, 0x10, 0x14; RLAST on beat 4 only.
REQ-029 SHALL cover WRAP and FIXED: WRAP at 0x38, ARLEN=3, size 2 -> 0x38, 0x3C, 0x30, 0x34; FIXED at 0x20, ARLEN=2 -> 0x20 three times.
REQ-030 SHALL cover backpressure and response: S_RREADY=0 for 5 cycles during a 4-beat burst with SLVERR on beat 2 -> M_RREADY low while RVALID is held, no beat lost or reordered, SLVERR on beat 2 only.
REQ-031 SHALL cover a full FIFO: 16 bursts with ARLEN=0, M_ARREADY=0 -> ARREADY=0 after the 16th; back-to-back IDs 1 and 3 return in order.
REQ-032 SHALL cover reset mid-burst: reset during beat 2 of 4 -> next cycle M_ARVALID=0, S_RVALID=0 and ARREADY=0 until reset is released.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings: burst types and read response codes.
package axi_pkg;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
endpackage

// File: rtl/axi_addr.sv
// Next-beat address for an AXI burst (FIXED / INCR / WRAP, reserved as INCR).
module axi_addr
  import axi_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [AW-1:0] i_last_addr,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  input  logic [7:0]    i_len,
  output logic [AW-1:0] o_next_addr
);
  logic [AW-1:0] w_incr, w_wrap_mask;

  assign w_incr = AW'(1'b1) << i_size;
  // Legal WRAP lengths make the window a power of two, so size-1 is a mask.
  assign w_wrap_mask = ((AW'(i_len) + AW'(1'b1)) << i_size) - AW'(1'b1);

  // Select the address update for the burst type.
  always_comb begin
    o_next_addr = i_last_addr + w_incr;
    case (axi_burst_e'(i_burst))
      BURST_FIXED: o_next_addr = i_last_addr;
      BURST_WRAP:  o_next_addr = (i_last_addr & ~w_wrap_mask) |
                                 ((i_last_addr + w_incr) & w_wrap_mask);
      default:     o_next_addr = i_last_addr + w_incr;
    endcase
  end
endmodule

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO; a push is accepted while full
// if a pop happens in the same cycle.
module sfifo #(
  parameter int BW     = 10,
  parameter int LGFLEN = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [BW-1:0] i_data,
  output logic          o_full,
  input  logic          i_rd,
  output logic [BW-1:0] o_data,
  output logic          o_empty
);
  localparam logic [LGFLEN:0] PTR_ONE = (LGFLEN+1)'(1'b1);

  logic [BW-1:0] r_mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN:0] r_wptr, r_rptr;
  logic w_wr, w_rd;

  assign w_rd    = i_rd && !o_empty;
  assign w_wr    = i_wr && (!o_full || w_rd);
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[LGFLEN] != r_rptr[LGFLEN]) &&
                   (r_wptr[LGFLEN-1:0] == r_rptr[LGFLEN-1:0]);
  assign o_data  = r_mem[r_rptr[LGFLEN-1:0]];

  // Read/write pointers; the extra MSB separates full from empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[LGFLEN-1:0]] <= i_data;
  end
endmodule

// File: rtl/axi_slave_read.sv
// AXI4 read slave that splits each burst into single AXI-lite reads and
// reassembles the responses with ID and RLAST from a burst FIFO.
module axi_slave_read
  import axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 2,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int LGFIFO             = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARLOCK,
  input  logic [3:0]                    S_AXI_ARCACHE,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic [3:0]                    S_AXI_ARQOS,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);
  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int FW = IW + 8;

  logic          r_mvalid;
  logic [7:0]    r_beats_left, r_len, r_bcnt;
  logic [AW-1:0] r_maddr;
  logic [2:0]    r_size, r_prot;
  logic [1:0]    r_burst, r_rresp;
  logic          r_svalid, r_rlast;
  logic [IW-1:0] r_rid;
  logic [DW-1:0] r_rdata;

  logic          w_s_arready, w_ar_hs, w_mar_hs, w_mr_hs, w_last_beat;
  logic          w_fifo_full, w_fifo_empty, w_unused;
  logic [FW-1:0] w_head;
  logic [AW-1:0] w_next_addr;

  assign w_s_arready = !S_AXI_ARESET && !w_fifo_full &&
                       (!r_mvalid || (r_beats_left == 8'd0 && M_AXI_ARREADY));
  assign w_ar_hs     = S_AXI_ARVALID && w_s_arready;
  assign w_mar_hs    = r_mvalid && M_AXI_ARREADY;
  assign w_mr_hs     = M_AXI_RVALID && M_AXI_RREADY;
  assign w_last_beat = (r_bcnt == w_head[7:0]);
  assign w_unused    = &{1'b0, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, w_fifo_empty};

  assign S_AXI_ARREADY = w_s_arready;
  assign M_AXI_ARVALID = r_mvalid;
  assign M_AXI_ARADDR  = r_maddr;
  assign M_AXI_ARPROT  = r_prot;
  assign M_AXI_RREADY  = !r_svalid || S_AXI_RREADY;
  assign S_AXI_RVALID  = r_svalid;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;

  sfifo #(.BW(FW), .LGFLEN(LGFIFO)) u_burst_fifo (
    .i_clk   (S_AXI_ACLK),
    .i_reset (S_AXI_ARESET),
    .i_wr    (w_ar_hs),
    .i_data  ({S_AXI_ARID, S_AXI_ARLEN}),
    .o_full  (w_fifo_full),
    .i_rd    (w_mr_hs && w_last_beat),
    .o_data  (w_head),
    .o_empty (w_fifo_empty)
  );

  axi_addr #(.AW(AW)) u_next_addr (
    .i_last_addr (r_maddr),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .i_len       (r_len),
    .o_next_addr (w_next_addr)
  );

  // AR issue control: a new burst takes priority over retiring the last beat.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_mvalid     <= 1'b0;
      r_beats_left <= 8'd0;
    end else if (w_ar_hs) begin
      r_mvalid     <= 1'b1;
      r_beats_left <= S_AXI_ARLEN;
    end else if (w_mar_hs) begin
      if (r_beats_left != 8'd0) r_beats_left <= r_beats_left - 8'd1;
      else r_mvalid <= 1'b0;
    end
  end

  // Burst attributes and the walking address.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_ar_hs) begin
      r_maddr <= S_AXI_ARADDR;
      r_len   <= S_AXI_ARLEN;
      r_size  <= S_AXI_ARSIZE;
      r_burst <= S_AXI_ARBURST;
      r_prot  <= S_AXI_ARPROT;
    end else if (w_mar_hs && r_beats_left != 8'd0) begin
      r_maddr <= w_next_addr;
    end
  end

  // R handshake control and beat counting against the head burst length.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_svalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_bcnt   <= 8'd0;
    end else if (w_mr_hs) begin
      r_svalid <= 1'b1;
      r_rlast  <= w_last_beat;
      r_bcnt   <= w_last_beat ? 8'd0 : r_bcnt + 8'd1;
    end else if (S_AXI_RREADY) begin
      r_svalid <= 1'b0;
    end
  end

  // R payload, captured with each returned AXI-lite beat.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_mr_hs) begin
      r_rdata <= M_AXI_RDATA;
      r_rresp <= M_AXI_RRESP;
      r_rid   <= w_head[FW-1:8];
    end
  end
endmodule
